// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end for the serial residue machine: takes a word on a
// valid/ready handshake and plays it out MSB-first, framed by a clear pulse and a done pulse.
module serial_word_feeder #(
  parameter int WIDTH = 8,
  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             hold,
  output logic             I,
  output logic             bit_valid,
  output logic             frame_clr,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Handshake: a word transfers on a rising edge where din_valid && din_ready.
  // din_ready is high only in IDLE, so din is sampled exactly once per frame and
  // a producer may hold din_valid high across a whole frame without duplication.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (din_valid) begin
            sreg  <= din;
            cnt   <= CW'(WIDTH - 1);
            state <= CLEAR;
          end
        end
        CLEAR: state <= SHIFT;
        SHIFT: begin
          // A held cycle freezes everything so the same bit stays on I.
          if (!hold) begin
            sreg <= sreg << 1;
            if (cnt == '0) begin
              state <= DONE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs decode registered state; bit_valid additionally masks held
  // cycles so the residue stage never consumes a repeated bit.
  assign din_ready = (state == IDLE);
  assign frame_clr = (state == CLEAR);
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);
  assign I         = (state == SHIFT) & sreg[WIDTH-1];
  assign bit_valid = (state == SHIFT) & ~hold;
  assign state_dbg = state;

endmodule
